// File: rtl/motor_persiana.sv
// H-bridge drive stage for the blind motor: soft-start PWM ramp, dead time on stop or
// reversal, limit-switch interlock and travel-timeout fault latch.
module motor_persiana #(
  parameter int unsigned PWM_BITS       = 4,
  parameter int unsigned RAMP_STEP      = 64,
  parameter int unsigned DEAD_CYCLES    = 1000,
  parameter int unsigned TIMEOUT_CYCLES = 5000000
) (
  input  logic Reloj,
  input  logic reset,
  input  logic subir,
  input  logic bajar,
  input  logic Ssup,
  input  logic Sinf,
  input  logic borrar_falla,
  output logic m_arriba,
  output logic m_abajo,
  output logic moviendo,
  output logic falla
);

  localparam int unsigned DUTY_W   = PWM_BITS + 1;
  localparam int unsigned RAMP_W   = (RAMP_STEP > 1) ? $clog2(RAMP_STEP) : 1;
  localparam int unsigned DEAD_W   = $clog2(DEAD_CYCLES + 1);
  localparam int unsigned TRAVEL_W = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [DUTY_W-1:0]   DUTY_FULL  = DUTY_W'(2 ** PWM_BITS);
  localparam logic [RAMP_W-1:0]   RAMP_LAST  = RAMP_W'(RAMP_STEP - 1);
  localparam logic [DEAD_W-1:0]   DEAD_LOAD  = DEAD_W'(DEAD_CYCLES);
  localparam logic [TRAVEL_W-1:0] TRAVEL_END = TRAVEL_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    REPOSO   = 3'd0,
    ARRANQUE = 3'd1,
    MARCHA   = 3'd2,
    FRENO    = 3'd3,
    FALLA    = 3'd4
  } state_t;

  state_t              state_q, state_d;
  logic                dir_q, dir_d;          // 1 = up, 0 = down
  logic [DUTY_W-1:0]   duty_q, duty_d;
  logic [PWM_BITS-1:0] pwm_q, pwm_d;
  logic [RAMP_W-1:0]   ramp_q, ramp_d;
  logic [DEAD_W-1:0]   dead_q, dead_d;
  logic [TRAVEL_W-1:0] travel_q, travel_d;
  logic                arr_d, abj_d, mov_d, fal_d;

  logic cmd_up, cmd_dn, cmd_none, dir_blocked, dir_match, run_d;

  // Both commands high decode as NONE, so opposing requests never reach the bridge.
  assign cmd_up      = subir & ~bajar;
  assign cmd_dn      = bajar & ~subir;
  assign cmd_none    = ~(cmd_up | cmd_dn);
  assign dir_blocked = dir_q ? Ssup : Sinf;
  assign dir_match   = dir_q ? cmd_up : cmd_dn;

  always_ff @(posedge Reloj or negedge reset) begin
    if (!reset) begin
      state_q  <= REPOSO;
      dir_q    <= 1'b0;
      duty_q   <= '0;
      pwm_q    <= '0;
      ramp_q   <= '0;
      dead_q   <= '0;
      travel_q <= '0;
      m_arriba <= 1'b0;
      m_abajo  <= 1'b0;
      moviendo <= 1'b0;
      falla    <= 1'b0;
    end else begin
      state_q  <= state_d;
      dir_q    <= dir_d;
      duty_q   <= duty_d;
      pwm_q    <= pwm_d;
      ramp_q   <= ramp_d;
      dead_q   <= dead_d;
      travel_q <= travel_d;
      m_arriba <= arr_d;
      m_abajo  <= abj_d;
      moviendo <= mov_d;
      falla    <= fal_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    dir_d    = dir_q;
    duty_d   = duty_q;
    pwm_d    = pwm_q;
    ramp_d   = ramp_q;
    dead_d   = dead_q;
    travel_d = travel_q;
    run_d    = 1'b0;
    arr_d    = 1'b0;
    abj_d    = 1'b0;
    mov_d    = 1'b0;
    fal_d    = 1'b0;

    unique case (state_q)
      REPOSO: begin
        if ((cmd_up && !Ssup) || (cmd_dn && !Sinf)) begin
          state_d  = ARRANQUE;
          dir_d    = cmd_up;
          duty_d   = DUTY_W'(1);
          pwm_d    = '0;
          ramp_d   = '0;
          travel_d = '0;
        end
      end

      ARRANQUE, MARCHA: begin
        travel_d = travel_q + TRAVEL_W'(1);
        pwm_d    = pwm_q + PWM_BITS'(1);
        if (state_q == ARRANQUE) begin
          if (ramp_q == RAMP_LAST) begin
            ramp_d = '0;
            duty_d = duty_q + DUTY_W'(1);
          end else begin
            ramp_d = ramp_q + RAMP_W'(1);
          end
          if (duty_d == DUTY_FULL) begin
            state_d = MARCHA;
          end
        end
        // Timeout outranks the limit switch, which outranks a command change.
        if (travel_q == TRAVEL_END) begin
          state_d = FALLA;
        end else if (dir_blocked || !dir_match) begin
          state_d = FRENO;
          dead_d  = DEAD_LOAD;
        end
      end

      FRENO: begin
        if (dead_q != '0) begin
          dead_d = dead_q - DEAD_W'(1);
        end
        if (dead_q <= DEAD_W'(1)) begin
          state_d = REPOSO;
        end
      end

      FALLA: begin
        if (borrar_falla && cmd_none) begin
          state_d = REPOSO;
        end
      end

      default: begin
        state_d = REPOSO;
      end
    endcase

    // Outputs are registered from the next-state values so they change on the deciding edge.
    run_d = ((state_d == ARRANQUE) && ({1'b0, pwm_d} < duty_d)) || (state_d == MARCHA);
    arr_d = run_d & dir_d;
    abj_d = run_d & ~dir_d;
    mov_d = (state_d == ARRANQUE) || (state_d == MARCHA);
    fal_d = (state_d == FALLA);
  end

endmodule

// File: doc/motor_persiana.md
# motor_persiana

Motor-drive stage directly downstream of the blind FSM pair. It consumes the `subir`/`bajar` commands and produces H-bridge drive signals `m_arriba`/`m_abajo` with these protections:
- soft-start PWM ramp;
- mandatory dead time before any stop or reversal;
- hard limit-switch interlock;
- travel-timeout fault latch.

It guarantees the bridge is never driven in both directions at once, whatever the upstream command sequence.

## Interface
- `PWM_BITS`, 4: PWM counter width. PWM period is 2^PWM_BITS cycles.
- `RAMP_STEP`, 64: cycles spent at each duty level during soft start.
- `DEAD_CYCLES`, 1000: cycles with both outputs low after any run ends.
- `TIMEOUT_CYCLES`, 5000000: maximum continuous run cycles before a fault.

Ports:
- `Reloj`  in  1  system clock; all logic is on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `subir`  in  1  raise command from the upstream FSM.
- `bajar`  in  1  lower command from the upstream FSM.
- `Ssup`  in  1  upper limit switch; 1 = fully open.
- `Sinf`  in  1  lower limit switch; 1 = fully closed.
- `borrar_falla`  in  1  fault clear request.
- `m_arriba`  out  1  drive up, registered.
- `m_abajo`  out  1  drive down, registered.
- `moviendo`  out  1  high in ARRANQUE or MARCHA.
- `falla`  out  1  high in FALLA.

## Operation
Command decode:
- UP = `subir & ~bajar`; DOWN = `bajar & ~subir`; anything else = NONE (both high is treated as NONE).
- A direction is *blocked* when it is UP with `Ssup`=1, or DOWN with `Sinf`=1.

States:
- **REPOSO**: outputs 0. An unblocked UP or DOWN latches `dir`, sets duty=1, clears `pwm_cnt`, the ramp counter and the travel counter, and moves to ARRANQUE.
- **ARRANQUE**:
  - The active output follows `pwm_cnt < duty`. `pwm_cnt` is PWM_BITS wide, free-running, wraps to 0.
  - Duty is PWM_BITS+1 bits wide. It increments after every RAMP_STEP cycles in this state.
  - When duty reaches 2^PWM_BITS, go to MARCHA on that same edge.
- **MARCHA**: the active output is continuously 1.
- **Exit from ARRANQUE/MARCHA**: when the command no longer equals `dir` (NONE or opposite), or `dir` becomes blocked, go to FRENO and load the dead counter with DEAD_CYCLES.
- **Travel counter**: counts every cycle in ARRANQUE and MARCHA. When it reaches TIMEOUT_CYCLES, go to FALLA.
- **FRENO**: outputs 0 and all commands are ignored. After DEAD_CYCLES cycles, go to REPOSO. A reversal therefore always passes through FRENO and REPOSO.
- **FALLA**: outputs 0, `falla`=1. Leave to REPOSO only when `borrar_falla`=1 and the command is NONE in the same cycle.

Priority when events coincide in ARRANQUE/MARCHA: timeout beats limit, which beats command change. FALLA wins over FRENO.

Invariants:
- `m_arriba & m_abajo` is never 1.
- An output is never 1 while its limit switch is 1, except for the single registered cycle after the switch rises.

## Timing
- Reset asserted, at any time including mid-run: state REPOSO, all counters 0, and `m_arriba`, `m_abajo`, `moviendo`, `falla` all 0 immediately (asynchronous). Release is synchronous to the next `Reloj` edge.
- Command sampled at edge k gives state ARRANQUE after edge k. The first PWM-high output cycle is the cycle after edge k, because `pwm_cnt`=0 is less than duty=1.
- Soft start lasts (2^PWM_BITS − 1) × RAMP_STEP cycles, after which the output stays high.
- Command drop, or a limit switch rising, sampled at edge k forces outputs to 0 after edge k. REPOSO is entered after edge k+DEAD_CYCLES, and a new command can be accepted at edge k+DEAD_CYCLES+1.
- The timeout is reached on the TIMEOUT_CYCLES-th run cycle; `falla` is high from the following cycle.
- Inputs are synchronous to `Reloj`; they are synchronized and debounced upstream.

## Test plan
Bench parameters: PWM_BITS=2, RAMP_STEP=4, DEAD_CYCLES=3, TIMEOUT_CYCLES=40.

1. **Soft start.** Hold `subir`=1, `Ssup`=0 from edge 0.
   - `m_arriba` pattern: 1000 ×1, 1100 ×1, 1110 ×1, then constant 1 from the 13th drive cycle.
   - `m_abajo` stays 0.
2. **Reversal.** In MARCHA UP, switch to `bajar`=1.
   - `m_arriba` is 0 on the next cycle, then 3 cycles of dead time with both outputs 0, then REPOSO.
   - `m_abajo` begins its ramp one cycle after that.
3. **Limit interlock.**
   - While running DOWN, raise `Sinf`: outputs 0 on the next cycle, `moviendo` drops, FRENO.
   - In REPOSO with `Sinf`=1, assert `bajar`: nothing happens.
4. **Timeout.** Hold `subir`=1 with `Ssup`=0 for 45 cycles.
   - `falla`=1 after 40 run cycles and outputs go to 0.
   - `borrar_falla` with `subir` still high has no effect.
   - Releasing `subir`, then pulsing `borrar_falla`, returns to REPOSO.
5. **Illegal and asynchronous inputs.**
   - `subir`=`bajar`=1 in REPOSO: outputs stay 0.
   - Pulse `reset` low mid-MARCHA: outputs drop without waiting for an edge, and the next run restarts the ramp from duty=1.
